// File: rtl/regfile_multiport.sv
// -----------------------------------------------------------------------------
// regfile_multiport
//   Parametrised register file: one synchronous write port, NRD combinational
//   read ports, optional same-cycle write-to-read bypass and a hardware clear
//   sweep that zeroes every entry, one per clock, while BUSY is high.
//
// Parameters
//   WIDTH  : bits per register
//   DEPTH  : number of registers (>= 2, need not be a power of two)
//   NRD    : number of read ports (>= 1)
//   BYPASS : 1 forwards a qualifying same-cycle write to matching read ports
//   AW     : address width, derived from DEPTH (not overridable)
//
// Ports
//   CLKb  in   clock, rising edge
//   RSTb  in   asynchronous active-low reset
//   D     in   write data
//   ENW   in   write enable
//   WRA   in   write address
//   ENR   in   per-port read enable, bit i -> port i
//   RDA   in   read addresses, port i at [i*AW +: AW]
//   Q     out  read data, port i at [i*WIDTH +: WIDTH]
//   CLR   in   one-cycle request to start a clear sweep
//   BUSY  out  high while the clear sweep runs
// -----------------------------------------------------------------------------
module regfile_multiport #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 4,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   CLKb,
    input  logic                   RSTb,
    input  logic [WIDTH-1:0]       D,
    input  logic                   ENW,
    input  logic [AW-1:0]          WRA,
    input  logic [NRD-1:0]         ENR,
    input  logic [NRD*AW-1:0]      RDA,
    output logic [NRD*WIDTH-1:0]   Q,
    input  logic                   CLR,
    output logic                   BUSY
);

    // One extra bit so DEPTH itself is representable for range checks even
    // when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [AW-1:0]      r_ptr;
    logic [AW-1:0]      w_ptr_nxt;
    logic               r_busy;

    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_wr_ok;
    logic [DEPTH-1:0]   w_wr_hit;
    logic [DEPTH-1:0]   w_clr_hit;
    logic [AW-1:0]      w_ra [NRD];

    // Clear FSM state register; BUSY is registered from the next state so it
    // mirrors (state == CLEAR) exactly.
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= (w_state_nxt == ST_CLEAR);
        end
    end

    // Clear FSM next-state logic: CLR starts the sweep from entry 0; the
    // sweep walks every entry once and ignores further CLR pulses.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (CLR) begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_state_nxt = ST_CLEAR;
                    w_ptr_nxt   = r_ptr + AW'(1'b1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // FSM outputs: per-entry write and clear strobes. CLR has priority over a
    // write in IDLE, and no write qualifies while reset is held, which also
    // blocks the bypass path during reset.
    always_comb begin
        w_wr_hit  = '0;
        w_clr_hit = '0;
        w_wr_ok   = RSTb && ENW && (r_state == ST_IDLE) && !CLR &&
                    ({1'b0, WRA} < DEPTH_W);
        for (int i = 0; i < DEPTH; i++) begin
            w_wr_hit[i]  = w_wr_ok && (WRA == AW'(i));
            w_clr_hit[i] = (r_state == ST_CLEAR) && (r_ptr == AW'(i));
        end
    end

    // Storage array: sweep clear takes precedence, otherwise a qualifying write.
    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_clr_hit[i]) begin
                    r_mem[i] <= '0;
                end else if (w_wr_hit[i]) begin
                    r_mem[i] <= D;
                end
            end
        end
    end

    // Combinational read ports. w_wr_ok is already false during a sweep, so
    // the bypass is naturally disabled there.
    always_comb begin
        Q = '0;
        for (int p = 0; p < NRD; p++) begin
            w_ra[p] = RDA[p*AW +: AW];
        end
        for (int p = 0; p < NRD; p++) begin
            if (ENR[p] && ({1'b0, w_ra[p]} < DEPTH_W)) begin
                if ((BYPASS != 32'sd0) && w_wr_ok && (WRA == w_ra[p])) begin
                    Q[p*WIDTH +: WIDTH] = D;
                end else begin
                    Q[p*WIDTH +: WIDTH] = r_mem[w_ra[p]];
                end
            end else begin
                Q[p*WIDTH +: WIDTH] = '0;
            end
        end
    end

    assign BUSY = r_busy;

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

    localparam int S_AQ0 = 0, S_AQ1 = 1, S_AB = 2, S_BQ0 = 3, S_BQ1 = 4,
                   S_BB = 5, S_CQ0 = 6, S_CQ1 = 7, S_CQ2 = 8, S_CB = 9;

    typedef struct {
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk;
    logic rst_a, rst_bc;

    // DUT A: defaults (WIDTH 10, DEPTH 4, NRD 2, BYPASS 1)
    logic [9:0]  a_d;  logic a_enw; logic [1:0] a_wra; logic [1:0] a_enr;
    logic [3:0]  a_rda; logic [19:0] a_q; logic a_clr; logic a_busy;
    // DUT B: BYPASS 0
    logic [9:0]  b_d;  logic b_enw; logic [1:0] b_wra; logic [1:0] b_enr;
    logic [3:0]  b_rda; logic [19:0] b_q; logic b_clr; logic b_busy;
    // DUT C: DEPTH 5, NRD 3
    logic [9:0]  c_d;  logic c_enw; logic [2:0] c_wra; logic [2:0] c_enr;
    logic [8:0]  c_rda; logic [29:0] c_q; logic c_clr; logic c_busy;

    regfile_multiport dut_a (
        .CLKb(clk), .RSTb(rst_a), .D(a_d), .ENW(a_enw), .WRA(a_wra),
        .ENR(a_enr), .RDA(a_rda), .Q(a_q), .CLR(a_clr), .BUSY(a_busy)
    );

    regfile_multiport #(.BYPASS(0)) dut_b (
        .CLKb(clk), .RSTb(rst_bc), .D(b_d), .ENW(b_enw), .WRA(b_wra),
        .ENR(b_enr), .RDA(b_rda), .Q(b_q), .CLR(b_clr), .BUSY(b_busy)
    );

    regfile_multiport #(.DEPTH(5), .NRD(3)) dut_c (
        .CLKb(clk), .RSTb(rst_bc), .D(c_d), .ENW(c_enw), .WRA(c_wra),
        .ENR(c_enr), .RDA(c_rda), .Q(c_q), .CLR(c_clr), .BUSY(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_AQ0:   return {22'd0, a_q[9:0]};
            S_AQ1:   return {22'd0, a_q[19:10]};
            S_AB:    return {31'd0, a_busy};
            S_BQ0:   return {22'd0, b_q[9:0]};
            S_BQ1:   return {22'd0, b_q[19:10]};
            S_BB:    return {31'd0, b_busy};
            S_CQ0:   return {22'd0, c_q[9:0]};
            S_CQ1:   return {22'd0, c_q[19:10]};
            S_CQ2:   return {22'd0, c_q[29:20]};
            S_CB:    return {31'd0, c_busy};
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.sel  = sel;
        e.val  = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    // Monitor: at each falling edge, compare every queued expectation.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = actual(e.sel);
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic enw, input logic [1:0] wra, input logic [9:0] d,
                         input logic [1:0] enr, input logic [3:0] rda, input logic clr);
        a_enw = enw; a_wra = wra; a_d = d; a_enr = enr; a_rda = rda; a_clr = clr;
    endtask

    task automatic set_b(input logic enw, input logic [1:0] wra, input logic [9:0] d,
                         input logic [1:0] enr, input logic [3:0] rda);
        b_enw = enw; b_wra = wra; b_d = d; b_enr = enr; b_rda = rda; b_clr = 1'b0;
    endtask

    task automatic set_c(input logic enw, input logic [2:0] wra, input logic [9:0] d,
                         input logic [2:0] enr, input logic [8:0] rda, input logic clr);
        c_enw = enw; c_wra = wra; c_d = d; c_enr = enr; c_rda = rda; c_clr = clr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r1;
        rst_a  = 1'b0;
        rst_bc = 1'b0;
        set_a(1'b0, 2'd0, 10'd0, 2'b11, 4'($urandom()), 1'b0);
        set_b(1'b0, 2'd0, 10'd0, 2'b11, 4'($urandom()));
        set_c(1'b0, 3'd0, 10'd0, 3'b111, 9'($urandom()), 1'b0);

        // Reset state: all reads zero, not busy
        @(posedge clk); #1;
        push(S_AQ0, 32'h0, "rst_a_q0"); push(S_AQ1, 32'h0, "rst_a_q1");
        push(S_AB,  32'h0, "rst_a_busy");
        push(S_BQ0, 32'h0, "rst_b_q0"); push(S_BQ1, 32'h0, "rst_b_q1");
        push(S_CQ0, 32'h0, "rst_c_q0"); push(S_CQ1, 32'h0, "rst_c_q1");
        push(S_CQ2, 32'h0, "rst_c_q2"); push(S_CB,  32'h0, "rst_c_busy");
        step(); rst_a = 1'b1; rst_bc = 1'b1;
        set_a(1'b0, 2'd0, 10'd0, 2'b00, 4'd0, 1'b0);
        set_b(1'b0, 2'd0, 10'd0, 2'b00, 4'd0);
        set_c(1'b0, 3'd0, 10'd0, 3'b000, 9'd0, 1'b0);

        // Write then two-port read
        step(); set_a(1'b1, 2'd1, 10'h3FF, 2'b00, 4'd0, 1'b0);
        step(); set_a(1'b1, 2'd3, 10'h2AA, 2'b00, 4'd0, 1'b0);
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b11, {2'd3, 2'd1}, 1'b0);
        push(S_AQ0, 32'h3FF, "rd_q0"); push(S_AQ1, 32'h2AA, "rd_q1");
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b01, {2'd3, 2'd1}, 1'b0);
        push(S_AQ0, 32'h3FF, "rd_en01_q0"); push(S_AQ1, 32'h0, "rd_en01_q1");

        // Bypass enabled: same-cycle forwarding to both ports
        step(); set_a(1'b1, 2'd2, 10'h123, 2'b11, {2'd2, 2'd2}, 1'b0);
        push(S_AQ0, 32'h123, "byp_q0"); push(S_AQ1, 32'h123, "byp_q1");
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b00, 4'd0, 1'b0);

        // Bypass disabled: old value until the edge
        step(); set_b(1'b1, 2'd2, 10'h0AB, 2'b00, 4'd0);
        step(); set_b(1'b1, 2'd2, 10'h123, 2'b01, {2'd0, 2'd2});
        push(S_BQ0, 32'h0AB, "nobyp_old");
        step(); set_b(1'b0, 2'd2, 10'h000, 2'b01, {2'd0, 2'd2});
        push(S_BQ0, 32'h123, "nobyp_new");

        // Asynchronous reset between edges
        step(); set_a(1'b1, 2'd2, 10'h155, 2'b00, 4'd0, 1'b0);
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b01, {2'd0, 2'd2}, 1'b0);
        push(S_AQ0, 32'h155, "pre_arst_q0");
        step(); #1 rst_a = 1'b0;
        push(S_AQ0, 32'h0, "arst_q0"); push(S_AB, 32'h0, "arst_busy");
        step(); rst_a = 1'b1;

        // Fill, then sweep with a write held on the bus
        for (int i = 0; i < 4; i++) begin
            step(); set_a(1'b1, 2'(i), 10'(17 * (i + 1)), 2'b00, 4'd0, 1'b0);
        end
        step(); set_a(1'b1, 2'd0, 10'h0F0, 2'b01, {2'd0, 2'd0}, 1'b1);
        push(S_AB, 32'h0, "clr_cyc_busy"); push(S_AQ0, 32'h011, "clr_cyc_nobyp");
        for (int j = 0; j < 4; j++) begin
            r1 = (j == 0) ? 2'd3 : 2'(j - 1);
            step(); set_a(1'b1, 2'd0, 10'h0F0, 2'b11, {r1, 2'(j)}, (j == 1));
            push(S_AB, 32'h1, "sweep_busy");
            push(S_AQ0, 32'(17 * (j + 1)), "sweep_cur_old");
            push(S_AQ1, (j == 0) ? 32'h044 : 32'h0, "sweep_prev_zero");
        end
        step(); set_a(1'b1, 2'd1, 10'h077, 2'b11, {2'd1, 2'd0}, 1'b0);
        push(S_AB, 32'h0, "sweep_done_busy"); push(S_AQ0, 32'h0, "sweep_mem0");
        push(S_AQ1, 32'h077, "post_sweep_byp");
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b11, {2'd1, 2'd0}, 1'b0);
        push(S_AQ0, 32'h0, "post_sweep_mem0"); push(S_AQ1, 32'h077, "post_sweep_wr");

        // Reset on the second sweep cycle aborts; fresh write works
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b00, 4'd0, 1'b1);
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b00, 4'd0, 1'b0);
        push(S_AB, 32'h1, "abort_busy_on");
        step(); #1 rst_a = 1'b0;
        push(S_AB, 32'h0, "abort_busy_off");
        step(); rst_a = 1'b1;
        step(); set_a(1'b1, 2'd2, 10'h2C3, 2'b00, 4'd0, 1'b0);
        push(S_AB, 32'h0, "abort_idle");
        step(); set_a(1'b0, 2'd0, 10'h000, 2'b01, {2'd0, 2'd2}, 1'b0);
        push(S_AQ0, 32'h2C3, "abort_fresh_wr");

        // DEPTH 5, NRD 3
        step(); set_c(1'b1, 3'd0, 10'h0A5, 3'b000, 9'd0, 1'b0);
        step(); set_c(1'b1, 3'd4, 10'h35A, 3'b000, 9'd0, 1'b0);
        step(); set_c(1'b1, 3'd6, 10'h3FF, 3'b111, {3'd4, 3'd4, 3'd0}, 1'b0);
        push(S_CQ0, 32'h0A5, "c_rd_0"); push(S_CQ1, 32'h35A, "c_rd_4a");
        push(S_CQ2, 32'h35A, "c_rd_4b");
        step(); set_c(1'b0, 3'd0, 10'h000, 3'b111, {3'd4, 3'd6, 3'd7}, 1'b0);
        push(S_CQ0, 32'h0, "c_rda7"); push(S_CQ1, 32'h0, "c_rda6");
        push(S_CQ2, 32'h35A, "c_rd_4c");
        step(); set_c(1'b0, 3'd0, 10'h000, 3'b111, {3'd3, 3'd2, 3'd1}, 1'b0);
        push(S_CQ0, 32'h0, "c_rd_1"); push(S_CQ1, 32'h0, "c_rd_2");
        push(S_CQ2, 32'h0, "c_rd_3");
        step(); set_c(1'b0, 3'd0, 10'h000, 3'b011, {3'd0, 3'd4, 3'd0}, 1'b1);
        push(S_CB, 32'h0, "c_clr_cyc"); push(S_CQ0, 32'h0A5, "c_pre_sweep0");
        for (int j = 0; j < 5; j++) begin
            step(); set_c(1'b0, 3'd0, 10'h000, 3'b011, {3'd0, 3'd4, 3'd0}, 1'b0);
            push(S_CB, 32'h1, "c_sweep_busy");
            push(S_CQ0, (j == 0) ? 32'h0A5 : 32'h0, "c_sweep_e0");
            push(S_CQ1, 32'h35A, "c_sweep_e4");
        end
        step();
        push(S_CB, 32'h0, "c_sweep_done"); push(S_CQ1, 32'h0, "c_sweep_e4_zero");
        step();

        checks++;
        if (c_busy !== 1'b0) begin
            errors++;
            $display("FAIL c_final_busy: got %0b expected 0", c_busy);
        end
        checks++;
        if (c_q[19:10] !== 10'h000) begin
            errors++;
            $display("FAIL c_final_e4: got 0x%0h expected 0x0", c_q[19:10]);
        end
        if (checks < 12) begin
            errors++;
            $display("FAIL too few checks executed: %0d", checks);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
